// File: rtl/aes_req_scheduler.sv
// Round-robin front end that shares one AES-128 pipeline among NUM_REQ requesters.
// A tag FIFO records the owner of every accepted block so ciphertexts are routed back in order.
module aes_req_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_LEN     = 128,
   parameter int KEY_LEN      = 128,
   parameter int MAX_INFLIGHT = 32,
   parameter int ID_W         = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]      req_data,
   input  logic [NUM_REQ*KEY_LEN-1:0]       req_key,
   output logic                             core_data_valid_in,
   output logic                             core_key_valid_in,
   output logic [DATA_LEN-1:0]              core_plain_text,
   output logic [KEY_LEN-1:0]               core_cipher_key,
   input  logic                             core_data_valid_out,
   input  logic [DATA_LEN-1:0]              core_cipher_text,
   output logic                             rsp_valid,
   output logic [ID_W-1:0]                  rsp_id,
   output logic [DATA_LEN-1:0]              rsp_data,
   output logic [$clog2(MAX_INFLIGHT):0]    inflight,
   output logic                             err_underflow
);

   localparam int PTR_W = $clog2(MAX_INFLIGHT);
   localparam int CNT_W = PTR_W + 1;

   // Handshake: a requester's block is taken on a rising edge where req_valid[i] & req_ready[i];
   // req_ready is a one-hot grant that may depend on req_valid, and the requester must keep
   // valid/data/key stable until it is taken. The response side has no backpressure.

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic             grant_found;
   logic             can_issue;
   logic [ID_W:0]    idx_wide;
   logic [ID_W-1:0]  idx;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
   logic             pop_ok;
   logic             underflow;

   // Occupancy of the tag FIFO equals inflight, so the counter doubles as the FIFO fill level.
   assign can_issue = enable & reset & (inflight < CNT_W'(MAX_INFLIGHT));
   assign pop_ok    = core_data_valid_out & (inflight != '0);
   assign underflow = core_data_valid_out & (inflight == '0);

   always_comb begin
      req_ready   = '0;
      grant_id    = '0;
      grant_found = 1'b0;
      idx_wide    = '0;
      idx         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_wide = (ID_W+1)'(rr_ptr) + (ID_W+1)'(i);
         if (idx_wide >= (ID_W+1)'(NUM_REQ))
            idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
         idx = idx_wide[ID_W-1:0];
         if (!grant_found && can_issue && req_valid[idx]) begin
            grant_found    = 1'b1;
            grant_id       = idx;
            req_ready[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (grant_found)
         tag_mem[wr_ptr] <= grant_id;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr             <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         inflight           <= '0;
         core_data_valid_in <= 1'b0;
         core_key_valid_in  <= 1'b0;
         core_plain_text    <= '0;
         core_cipher_key    <= '0;
         rsp_valid          <= 1'b0;
         rsp_id             <= '0;
         rsp_data           <= '0;
         err_underflow      <= 1'b0;
      end else begin
         core_data_valid_in <= grant_found;
         core_key_valid_in  <= grant_found;
         if (grant_found) begin
            rr_ptr          <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
            core_plain_text <= req_data[grant_id*DATA_LEN +: DATA_LEN];
            core_cipher_key <= req_key[grant_id*KEY_LEN +: KEY_LEN];
         end else begin
            core_plain_text <= '0;
            core_cipher_key <= '0;
         end

         rsp_valid <= pop_ok;
         if (pop_ok) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rsp_id   <= tag_mem[rd_ptr];
            rsp_data <= core_cipher_text;
         end

         if (underflow)
            err_underflow <= 1'b1;

         case ({grant_found, pop_ok})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural pipeline stand-in whose returns
// can be throttled (budget) or forced while nothing is in flight.
module tb_aes_req_scheduler;

   localparam int NR = 4;
   localparam int DL = 128;
   localparam int KL = 128;
   localparam int MI = 4;
   localparam int IW = 2;

   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic              clk;
   logic              reset;
   logic              enable;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DL-1:0]  req_data;
   logic [NR*KL-1:0]  req_key;
   logic              core_data_valid_in;
   logic              core_key_valid_in;
   logic [DL-1:0]     core_plain_text;
   logic [KL-1:0]     core_cipher_key;
   logic              core_data_valid_out;
   logic [DL-1:0]     core_cipher_text;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [DL-1:0]     rsp_data;
   logic [2:0]        inflight;
   logic              err_underflow;

   logic [127:0]  d_arr [NR];
   logic [127:0]  k_arr [NR];
   logic [127:0]  pipe_q [$];
   logic [IW-1:0] got_id_q [$];
   logic [127:0]  got_data_q [$];
   int            budget;
   logic          force_uf;
   int            errors;
   int            checks;

   aes_req_scheduler #(
      .NUM_REQ(NR), .DATA_LEN(DL), .KEY_LEN(KL), .MAX_INFLIGHT(MI), .ID_W(IW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_key(req_key),
      .core_data_valid_in(core_data_valid_in), .core_key_valid_in(core_key_valid_in),
      .core_plain_text(core_plain_text), .core_cipher_key(core_cipher_key),
      .core_data_valid_out(core_data_valid_out), .core_cipher_text(core_cipher_text),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .inflight(inflight), .err_underflow(err_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      req_data = '0;
      req_key  = '0;
      for (int i = 0; i < NR; i++) begin
         req_data[i*DL +: DL] = d_arr[i];
         req_key[i*KL +: KL]  = k_arr[i];
      end
   end

   // Pipeline stand-in: the FIPS-197 vector maps to its real ciphertext, anything else to a mix.
   function automatic logic [127:0] model_cipher(input logic [127:0] p, input logic [127:0] k);
      if (p == P1 && k == K1) return C1;
      return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
   endfunction

   always @(posedge clk) begin
      if (reset && core_data_valid_in)
         pipe_q.push_back(model_cipher(core_plain_text, core_cipher_key));
   end

   always @(negedge clk) begin
      core_data_valid_out = 1'b0;
      if (force_uf) begin
         core_data_valid_out = 1'b1;
         core_cipher_text    = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
      end else if (budget > 0 && pipe_q.size() > 0) begin
         core_data_valid_out = 1'b1;
         core_cipher_text    = pipe_q.pop_front();
         budget              = budget - 1;
      end
   end

   always @(negedge clk) begin
      if (reset && rsp_valid) begin
         got_id_q.push_back(rsp_id);
         got_data_q.push_back(rsp_data);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset     = 1'b0;
      req_valid = '0;
      force_uf  = 1'b0;
      budget    = 0;
      pipe_q.delete();
      got_id_q.delete();
      got_data_q.delete();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_rsp(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (got_id_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset;
      reset     = 1'b0;
      enable    = 1'b1;
      req_valid = 4'b1111;
      tick();
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      checks++;
      if ({core_data_valid_in, core_key_valid_in, rsp_valid, err_underflow} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000",
                            {core_data_valid_in, core_key_valid_in, rsp_valid, err_underflow});
      end
      checks++;
      if (core_plain_text !== '0 || core_cipher_key !== '0 || rsp_data !== '0 || rsp_id !== '0) begin
         errors++; $display("FAIL reset_data: plain %h key %h rsp %h id %0d want all 0",
                            core_plain_text, core_cipher_key, rsp_data, rsp_id);
      end
      checks++;
      if (inflight !== 3'd0) begin
         errors++; $display("FAIL reset_inflight: got %0d want 0", inflight);
      end
      req_valid = '0;
      reset     = 1'b1;
   endtask

   task automatic test_single;
      bit ok;
      do_reset();
      d_arr[2]  = P1;
      k_arr[2]  = K1;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_grant: got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (core_data_valid_in !== 1'b1 || core_key_valid_in !== 1'b1) begin
         errors++; $display("FAIL single_issue_valid: got %b%b want 11",
                            core_data_valid_in, core_key_valid_in);
      end
      checks++;
      if (core_plain_text !== P1 || core_cipher_key !== K1) begin
         errors++; $display("FAIL single_issue_data: got %h/%h want %h/%h",
                            core_plain_text, core_cipher_key, P1, K1);
      end
      checks++;
      if (inflight !== 3'd1) begin
         errors++; $display("FAIL single_inflight: got %0d want 1", inflight);
      end
      tick();
      checks++;
      if (core_data_valid_in !== 1'b0 || core_plain_text !== '0) begin
         errors++; $display("FAIL single_issue_clear: valid %b data %h want 0", core_data_valid_in, core_plain_text);
      end
      budget = 1;
      wait_rsp(1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL single_rsp_timeout: got %0d responses want 1", got_id_q.size());
      end else begin
         checks++;
         if (got_id_q[0] !== 2'd2 || got_data_q[0] !== C1) begin
            errors++; $display("FAIL single_rsp: got id %0d data %h want id 2 data %h",
                               got_id_q[0], got_data_q[0], C1);
         end
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== C1 || rsp_id !== 2'd2 || inflight !== 3'd0) begin
         errors++; $display("FAIL single_hold: valid %b id %0d data %h inflight %0d want 0/2/%h/0",
                            rsp_valid, rsp_id, rsp_data, inflight, C1);
      end
   endtask

   task automatic test_round_robin;
      bit            ok;
      logic [IW-1:0] order [6];
      logic [NR-1:0] onehot;
      logic [IW-1:0] id;
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int i = 0; i < NR; i++) begin
         d_arr[i] = {4{32'h0101_0101 * (i + 1)}};
         k_arr[i] = {4{32'hf0e0_d0c0 ^ i}};
      end
      budget    = 1000;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         #1;
         onehot = '0;
         onehot[order[k]] = 1'b1;
         checks++;
         if (req_ready !== onehot) begin
            errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, onehot);
         end
         tick();
      end
      req_valid = '0;
      wait_rsp(6, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rr_rsp_timeout: got %0d responses want 6", got_id_q.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            id = order[k];
            checks++;
            if (got_id_q[k] !== id || got_data_q[k] !== model_cipher(d_arr[id], k_arr[id])) begin
               errors++; $display("FAIL rr_rsp%0d: got id %0d data %h want id %0d data %h", k,
                                  got_id_q[k], got_data_q[k], id, model_cipher(d_arr[id], k_arr[id]));
            end
         end
      end
   endtask

   task automatic test_enable;
      bit ok;
      do_reset();
      req_valid = 4'b0001;
      #1;
      tick();
      enable = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL enable_ready_off: got %b want 0000", req_ready);
      end
      tick();
      budget = 1;
      wait_rsp(1, ok);
      checks++;
      if (!ok || got_id_q[0] !== 2'd0 || inflight !== 3'd0) begin
         errors++; $display("FAIL enable_return: ok %b inflight %0d want return of id 0, inflight 0",
                            ok, inflight);
      end
      enable = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL enable_ready_on: got %b want 0001", req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_backpressure;
      do_reset();
      req_valid = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_accept%0d: got %b want 0001", k, req_ready);
         end
         tick();
      end
      #1;
      checks++;
      if (inflight !== 3'd4 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL bp_full: inflight %0d ready %b want 4/0000", inflight, req_ready);
      end
      tick();
      budget = 1;
      tick();
      checks++;
      if (inflight !== 3'd3 || req_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_one_return: inflight %0d ready %b want 3/0001", inflight, req_ready);
      end
      tick();
      checks++;
      if (inflight !== 3'd4 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL bp_refill: inflight %0d ready %b want 4/0000", inflight, req_ready);
      end
      tick();
      tick();
      checks++;
      if (inflight !== 3'd4 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL bp_hold: inflight %0d ready %b want 4/0000", inflight, req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_simultaneous;
      bit            ok;
      logic [IW-1:0] order [4];
      logic [IW-1:0] id;
      order = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0001;
      budget    = 1;
      #1;
      checks++;
      if (inflight !== 3'd3 || req_ready !== 4'b0001) begin
         errors++; $display("FAIL sim_pre: inflight %0d ready %b want 3/0001", inflight, req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (inflight !== 3'd3) begin
         errors++; $display("FAIL sim_inflight: got %0d want 3", inflight);
      end
      budget = 1000;
      wait_rsp(4, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL sim_rsp_timeout: got %0d responses want 4", got_id_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            id = order[k];
            checks++;
            if (got_id_q[k] !== id || got_data_q[k] !== model_cipher(d_arr[id], k_arr[id])) begin
               errors++; $display("FAIL sim_rsp%0d: got id %0d want %0d", k, got_id_q[k], id);
            end
         end
      end
      checks++;
      if (inflight !== 3'd0) begin
         errors++; $display("FAIL sim_drain: inflight %0d want 0", inflight);
      end
   endtask

   task automatic test_underflow;
      bit ok;
      do_reset();
      force_uf = 1'b1;
      tick();
      force_uf = 1'b0;
      checks++;
      if (err_underflow !== 1'b1 || inflight !== 3'd0 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL uf_flag: err %b inflight %0d rsp_valid %b want 1/0/0",
                            err_underflow, inflight, rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || got_id_q.size() != 0) begin
         errors++; $display("FAIL uf_no_rsp: rsp_valid %b data %h count %0d want 0/0/0",
                            rsp_valid, rsp_data, got_id_q.size());
      end
      req_valid = 4'b1000;
      #1;
      tick();
      req_valid = '0;
      budget    = 1000;
      wait_rsp(1, ok);
      checks++;
      if (!ok || got_id_q[0] !== 2'd3 || err_underflow !== 1'b1) begin
         errors++; $display("FAIL uf_sticky: ok %b err %b want return of id 3 with err 1", ok, err_underflow);
      end
      do_reset();
      checks++;
      if (err_underflow !== 1'b0) begin
         errors++; $display("FAIL uf_cleared: got %b want 0", err_underflow);
      end
   endtask

   task automatic test_reset_midop;
      do_reset();
      req_valid = 4'b1111;
      tick();
      tick();
      tick();
      req_valid = 4'b1010;
      #1;
      checks++;
      if (inflight !== 3'd3 || req_ready !== 4'b1000) begin
         errors++; $display("FAIL midop_pre: inflight %0d ready %b want 3/1000", inflight, req_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (inflight !== 3'd0 || req_ready !== 4'b0000 || rsp_valid !== 1'b0 ||
          core_data_valid_in !== 1'b0 || core_key_valid_in !== 1'b0) begin
         errors++; $display("FAIL midop_clear: inflight %0d ready %b rsp %b core %b%b want all 0",
                            inflight, req_ready, rsp_valid, core_data_valid_in, core_key_valid_in);
      end
      do_reset();
      req_valid = 4'b1010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL midop_first_grant: got %b want 0010", req_ready);
      end
      req_valid = '0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      budget    = 0;
      force_uf  = 1'b0;
      enable    = 1'b1;
      req_valid = '0;
      reset     = 1'b0;
      core_data_valid_out = 1'b0;
      core_cipher_text    = '0;
      for (int i = 0; i < NR; i++) begin
         d_arr[i] = '0;
         k_arr[i] = '0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_enable();
      test_backpressure();
      test_simultaneous();
      test_underflow();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
